pixel_feeder: RTL and testbench

PIXEL_FEEDER -- requirements
Module: pixel_feeder

---
 rtl/pixel_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_pixel_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_feeder.sv
// pixel_feeder: streams one frame from a frame RAM as raster pixels.
// Optional PIXEL_FEEDER_PAD_EN brackets every row with 4 zero pixels.
module pixel_feeder #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              en,
  output logic [DATA_W-1:0] d_out,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

`ifdef PIXEL_FEEDER_PAD_EN
  localparam int PAD = 4;
`else
  localparam int PAD = 0;
`endif
  localparam int ROW_LEN = IMG_W + 2 * PAD;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int OW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [OW-1:0] OCOL_LAST = OW'(ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

`ifdef PIXEL_FEEDER_PAD_EN
  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, DONE, PAD_PRE, PAD_POST
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;
`endif

  state_t            state;
  logic [CW-1:0]     rd_col;
  logic [RW-1:0]     rd_row;
  logic [OW-1:0]     ocol;
  logic [RW-1:0]     orow;
  logic              pend;
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  logic              rd_go;
  logic              pad_go;
  logic              emit;
  logic              row_end;
  logic              last_rd;
  logic              ocol_end;

  assign rd_go    = (state == READ) && !stall && !skid_v;
  assign mem_rd   = rd_go;
  assign row_end  = rd_col == COL_LAST;
  assign last_rd  = row_end && (rd_row == ROW_LAST);
  assign ocol_end = ocol == OCOL_LAST;

`ifdef PIXEL_FEEDER_PAD_EN
  logic [1:0] pad_cnt;
  assign pad_go = ((state == PAD_PRE) || (state == PAD_POST))
                  && !stall && !pend && !skid_v;
`else
  assign pad_go = 1'b0;
`endif

  // A pixel leaves whenever downstream is free and a source has one.
  assign emit = !stall && (skid_v || pend || pad_go);

  // Frame sequencing with registered busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef PIXEL_FEEDER_PAD_EN
      pad_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef PIXEL_FEEDER_PAD_EN
            state <= PAD_PRE;
`else
            state <= READ;
`endif
          end
        end
        READ: begin
`ifdef PIXEL_FEEDER_PAD_EN
          if (rd_go && row_end)
            state <= PAD_POST;
`else
          if (rd_go && last_rd)
            state <= DRAIN;
`endif
        end
`ifdef PIXEL_FEEDER_PAD_EN
        PAD_PRE: begin
          if (pad_go) begin
            pad_cnt <= pad_cnt + 1'b1;
            if (pad_cnt == 2'd3)
              state <= READ;
          end
        end
        PAD_POST: begin
          if (pad_go) begin
            pad_cnt <= pad_cnt + 1'b1;
            if (pad_cnt == 2'd3)
              state <= (orow == ROW_LAST) ? DRAIN : PAD_PRE;
          end
        end
`endif
        DRAIN: begin
          if (!pend && !skid_v) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster read addresses; wrap to 0 after the frame's last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_col   <= '0;
      rd_row   <= '0;
      mem_addr <= '0;
    end else if (rd_go) begin
      rd_col <= row_end ? '0 : rd_col + 1'b1;
      if (row_end)
        rd_row <= last_rd ? '0 : rd_row + 1'b1;
      mem_addr <= last_rd ? '0 : mem_addr + 1'b1;
    end
  end

  // Position of the next emitted pixel, used for the frame flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ocol <= '0;
      orow <= '0;
    end else if (emit) begin
      ocol <= ocol_end ? '0 : ocol + 1'b1;
      if (ocol_end)
        orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
    end
  end

  // Output stage: skid entry first, then RAM data, then pad zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      skid_v <= 1'b0;
      skid_d <= '0;
      en     <= 1'b0;
      d_out  <= '0;
      sof    <= 1'b0;
      eol    <= 1'b0;
      eof    <= 1'b0;
    end else begin
      pend <= rd_go;
      en   <= emit;
      sof  <= emit && (ocol == '0) && (orow == '0);
      eol  <= emit && ocol_end;
      eof  <= emit && ocol_end && (orow == ROW_LAST);
      if (stall) begin
        if (pend) begin
          skid_v <= 1'b1;
          skid_d <= mem_data;
        end
      end else begin
        unique case (1'b1)
          skid_v: begin
            d_out  <= skid_d;
            skid_v <= 1'b0;
          end
          pend:    d_out <= mem_data;
          pad_go:  d_out <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: directed vectors plus randomized stall frames
// checked against a queue-based model of the expected pixel stream.
module tb_pixel_feeder;

  localparam int DW = 12;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 8;
  localparam int N  = W * H;
`ifdef PIXEL_FEEDER_PAD_EN
  localparam int PAD = 4;
`else
  localparam int PAD = 0;
`endif
  localparam int RL = W + 2 * PAD;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          en;
  logic [DW-1:0] d_out;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ram [2**AW];

  pixel_feeder #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .en(en), .d_out(d_out), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM; garbage when no read was issued.
  always @(posedge clk)
    mem_data <= mem_rd ? ram[mem_addr] : DW'($urandom);

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic          en;
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          done;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } pix_t;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t sample();
    vec_t v;
    v.rd   = mem_rd;
    v.addr = mem_rd ? mem_addr : '0;
    v.en   = en;
    v.d    = d_out;
    v.sof  = sof;
    v.eol  = eol;
    v.eof  = eof;
    v.busy = busy;
    v.done = done;
    return v;
  endfunction

  // mode 0: no stall, 1: random stall, 2: stall cycles 4..6,
  // 3: no stall with extra starts mid-frame and on done.
  task automatic run_frame(input int mode, output int npix);
    pix_t q[$];
    pix_t p;
    int   nxt;
    int   dcnt;
    int   post;
    int   c;
    logic pst;
    npix = 0;
    for (int r = 0; r < H; r++) begin
      for (int k = 0; k < RL; k++) begin
        if (k < PAD || k >= PAD + W) p.d = '0;
        else p.d = ram[r * W + k - PAD];
        p.sof = (r == 0) && (k == 0);
        p.eol = (k == RL - 1);
        p.eof = p.eol && (r == H - 1);
        q.push_back(p);
      end
    end
    nxt  = 0;
    dcnt = 0;
    post = 0;
    c    = 0;
    pst  = 1'b0;
    while (post < 4 && c < 400) begin
      step();
      start = (c == 0) || (mode == 3 && (c == 5 || done));
      case (mode)
        1:       stall = $urandom_range(0, 99) < 35;
        2:       stall = (c >= 4) && (c <= 6);
        default: stall = 1'b0;
      endcase
      #1;
      if (c > 0) chk("busy", 64'(busy), 64'(dcnt == 0));
      if (pst) chk("en_after_stall", 64'(en), 64'd0);
      if (en) begin
        npix++;
        if (q.size() == 0) begin
          chk("extra_pixel", 64'(npix), 64'(RL * H));
        end else begin
          p = q.pop_front();
          chk("pixel", {d_out, sof, eol, eof},
              {p.d, p.sof, p.eol, p.eof});
        end
      end
      if (mem_rd) begin
        chk("rd_addr", 64'(mem_addr), 64'(nxt));
        chk("rd_in_stall", 64'(stall), 64'd0);
        nxt++;
      end
      if (done) begin
        chk("done_early", 64'(q.size()), 64'd0);
        dcnt++;
      end
      if (dcnt > 0) post++;
      pst = stall;
      c++;
    end
    start = 1'b0;
    stall = 1'b0;
    chk("done_count", 64'(dcnt), 64'd1);
    chk("read_count", 64'(nxt), 64'(N));
    chk("pixels_left", 64'(q.size()), 64'd0);
  endtask

  vec_t tbl [14];
  int   np;
  int   cnt;
  int   bad;

  initial begin
    for (int a = 0; a < 2**AW; a++) ram[a] = DW'(a + 1);
    for (int c = 0; c < 14; c++) begin
      tbl[c]      = '0;
      tbl[c].rd   = (c >= 1) && (c <= 8);
      tbl[c].addr = tbl[c].rd ? AW'(c - 1) : '0;
      tbl[c].en   = (c >= 3) && (c <= 10);
      if (c < 3) tbl[c].d = '0;
      else if (c <= 10) tbl[c].d = DW'(c - 2);
      else tbl[c].d = DW'(8);
      tbl[c].sof  = (c == 3);
      tbl[c].eol  = (c == 6) || (c == 10);
      tbl[c].eof  = (c == 10);
      tbl[c].busy = (c >= 1) && (c <= 11);
      tbl[c].done = (c == 11);
    end

    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) step();
    chk("reset_state",
        {mem_rd, mem_addr, en, d_out, sof, eol, eof, busy, done},
        '0);
    step();
    rst = 1'b0;

`ifndef PIXEL_FEEDER_PAD_EN
    for (int c = 0; c < 14; c++) begin
      step();
      start = (c == 0);
      #1;
      chk($sformatf("vec1_c%0d", c), 64'(sample()), 64'(tbl[c]));
    end
    start = 1'b0;
`endif

    run_frame(0, np);
    chk("plain_npix", 64'(np), 64'(RL * H));
    run_frame(2, np);
    chk("stall_npix", 64'(np), 64'(RL * H));
    run_frame(3, np);
    chk("restart_npix", 64'(np), 64'(RL * H));

    step();
    start = 1'b1;
    #1;
    cnt = 0;
    for (int g = 0; g < 50 && cnt < 5; g++) begin
      step();
      start = 1'b0;
      #1;
      if (en) cnt++;
    end
    chk("pre_rst_pixels", 64'(cnt), 64'd5);
    step();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_reset",
        {mem_rd, mem_addr, en, d_out, sof, eol, eof, busy, done},
        '0);
    bad = 0;
    for (int g = 0; g < 12; g++) begin
      step();
      #1;
      if (en || done || busy) bad++;
    end
    chk("quiet_after_rst", 64'(bad), 64'd0);

`ifndef PIXEL_FEEDER_PAD_EN
    for (int c = 0; c < 14; c++) begin
      step();
      start = (c == 0);
      #1;
      chk($sformatf("vec2_c%0d", c), 64'(sample()), 64'(tbl[c]));
    end
    start = 1'b0;
`else
    run_frame(0, np);
    chk("pad_after_rst", 64'(np), 64'(RL * H));
`endif

    for (int f = 0; f < 15; f++) begin
      for (int a = 0; a < N; a++) ram[a] = DW'($urandom);
      run_frame(1, np);
      chk("rand_npix", 64'(np), 64'(RL * H));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
